texture_mapper_texel_fetch: RTL

//  Upstream read-request stage for the texture dual-port RAM. Accepts (u,v) texel coordinates on a valid/ready handshake.
//  Per request, reads texel (u,v) on port A and its right neighbour (u+1,v) on port B, for bilinear filtering downstream.
//  Re-times the fixed-latency RAM read data into an output FIFO, so the downstream filter may stall without losing data.

---
 rtl/texture_mapper_texel_fetch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/texture_mapper_texel_fetch.sv
// Texel-pair read-request stage: (u,v) -> dual-port RAM reads of (u,v) and (u+1,v), re-timed into a show-ahead FIFO.
// Optional build macro TEXTURE_FETCH_CLAMP_EN selects clamp-to-edge addressing instead of wrap.
module texture_mapper_texel_fetch #(
    parameter int TEX_W_LOG2  = 4,
    parameter int TEX_H_LOG2  = 4,
    parameter int COORD_W     = 8,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [COORD_W-1:0]               req_u,
    input  logic [COORD_W-1:0]               req_v,
    output logic                             ram_clken,
    output logic [TEX_W_LOG2+TEX_H_LOG2-1:0] ram_address_a,
    output logic                             ram_read_en_a,
    output logic                             ram_write_en_a,
    input  logic [DATA_W-1:0]                ram_read_data_a,
    output logic [TEX_W_LOG2+TEX_H_LOG2-1:0] ram_address_b,
    output logic                             ram_read_en_b,
    output logic                             ram_write_en_b,
    input  logic [DATA_W-1:0]                ram_read_data_b,
    output logic                             texel_valid,
    input  logic                             texel_ready,
    output logic [DATA_W-1:0]                texel_a,
    output logic [DATA_W-1:0]                texel_b
);

    localparam int AW    = TEX_W_LOG2 + TEX_H_LOG2;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       occ;
    logic                   accept;
    logic                   pop;
    logic                   push;
    logic                   fifo_full;
    logic [TEX_W_LOG2-1:0]  x_p0;
    logic [TEX_W_LOG2-1:0]  xn_p0;
    logic [TEX_H_LOG2-1:0]  y_p0;
    logic [AW-1:0]          addr_a_p1;
    logic [AW-1:0]          addr_b_p1;
    logic                   rd_en_p1;
    logic [RAM_LATENCY-1:0] vld_p2;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [DATA_W-1:0]      mem_a [FIFO_DEPTH];
    logic [DATA_W-1:0]      mem_b [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits cover the whole accept-to-pop loop; sustained 1/cycle needs FIFO_DEPTH >= RAM_LATENCY+3.
    assign req_ready = !reset && (cnt < CNT_W'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = texel_valid && texel_ready;

    // Stage 0: coordinate to texel mapping
`ifdef TEXTURE_FETCH_CLAMP_EN
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'((1 << TEX_W_LOG2) - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'((1 << TEX_H_LOG2) - 1);

    always_comb begin
        x_p0  = (req_u > X_MAX) ? X_MAX[TEX_W_LOG2-1:0] : req_u[TEX_W_LOG2-1:0];
        y_p0  = (req_v > Y_MAX) ? Y_MAX[TEX_H_LOG2-1:0] : req_v[TEX_H_LOG2-1:0];
        xn_p0 = (x_p0 == '1) ? x_p0 : x_p0 + TEX_W_LOG2'(1);
    end
`else
    logic unused_coord_bits;
    assign unused_coord_bits = ^{req_u, req_v};

    always_comb begin
        x_p0  = req_u[TEX_W_LOG2-1:0];
        y_p0  = req_v[TEX_H_LOG2-1:0];
        xn_p0 = x_p0 + TEX_W_LOG2'(1);
    end
`endif

    // Stage 1: registered RAM addresses and read strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_a_p1 <= '0;
            addr_b_p1 <= '0;
            rd_en_p1  <= 1'b0;
        end else begin
            rd_en_p1 <= accept;
            if (accept) begin
                addr_a_p1 <= {y_p0, x_p0};
                addr_b_p1 <= {y_p0, xn_p0};
            end
        end
    end

    assign ram_clken      = 1'b1;
    assign ram_write_en_a = 1'b0;
    assign ram_write_en_b = 1'b0;
    assign ram_address_a  = addr_a_p1;
    assign ram_address_b  = addr_b_p1;
    assign ram_read_en_a  = rd_en_p1;
    assign ram_read_en_b  = rd_en_p1;

    // Stage 2: valid pipe matching the RAM read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2 <= '0;
        end else begin
            vld_p2[0] <= rd_en_p1;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_p2[i] <= vld_p2[i-1];
            end
        end
    end

    assign push = vld_p2[RAM_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Stage 3: output FIFO, show-ahead
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= ram_read_data_a;
            mem_b[wr_ptr] <= ram_read_data_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign fifo_full   = (occ == CNT_W'(FIFO_DEPTH));
    assign texel_valid = (occ != '0);
    assign texel_a     = texel_valid ? mem_a[rd_ptr] : '0;
    assign texel_b     = texel_valid ? mem_b[rd_ptr] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full))
        else $error("texel FIFO overflow");

endmodule
